// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter.
//   arb_state_e : arbiter FSM states
//   grant_e     : which requester is being handed the memory port this cycle
//   STRB_W      : byte-enable width for the default 32-bit data path
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_D,
    BUSY_I
  } arb_state_e;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_D,
    GNT_I
  } grant_e;

  localparam int DATA_W_DEF = 32;
  localparam int STRB_W     = DATA_W_DEF / 8;

endpackage

// File: rtl/arb_wait_timer.sv
// Wait timer for an outstanding memory request.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   clear      : restart the count (transaction finished)
//   count_en   : request outstanding and not acknowledged this cycle
//   expired    : this waiting cycle is the MAX_WAIT-th one; the access must be abandoned
module arb_wait_timer
  import mem_arb_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (count_en) begin
      cnt <= cnt + 8'd1;
    end
  end

  // cnt holds the number of waiting cycles already completed, so the
  // current cycle is the last permitted one when cnt reaches MAX_WAIT-1.
  assign expired = count_en && (cnt == 8'(MAX_WAIT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory bus between instruction fetch and data access.
// Data has fixed priority over fetch. Each requester holds its request level
// until it sees a one-cycle valid pulse. A hung access is abandoned after
// MAX_WAIT waiting cycles, completing with zero data and setting a sticky err.
// Ports:
//   if_req/if_addr            -> fetch request;  if_rdata/if_valid/if_stall back
//   d_req/d_we/d_addr/d_wdata/d_wstrb -> data request; d_rdata/d_valid/d_stall back
//   m_req/m_we/m_addr/m_wdata/m_wstrb -> memory bus; m_ack/m_rdata from memory
//   err                       -> sticky timeout flag, cleared by reset only
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_valid,
  output logic                if_stall,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_valid,
  output logic                d_stall,
  output logic                m_req,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic                m_ack,
  input  logic [DATA_W-1:0]   m_rdata,
  output logic                err
);

  arb_state_e state, state_nxt;
  grant_e     grant;
  logic       done;
  logic       timeout;
  logic       wait_en;
  logic       pend_d;
  logic       pend_i;

  assign wait_en = m_req && !m_ack;

  arb_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (done),
    .count_en (wait_en),
    .expired  (timeout)
  );

  // A request seen together with its own completion pulse is the tail of the
  // finished access, not a new one.
  assign pend_d = d_req && !d_valid;
  assign pend_i = if_req && !if_valid;

  assign if_stall = if_req && !if_valid;
  assign d_stall  = d_req && !d_valid;

  always_comb begin
    state_nxt = state;
    grant     = GNT_NONE;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (pend_d) begin
          grant = GNT_D;
        end else if (pend_i) begin
          grant = GNT_I;
        end
      end
      BUSY_D: begin
        if (m_ack || timeout) begin
          done = 1'b1;
          if (pend_i) begin
            grant = GNT_I;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      BUSY_I: begin
        if (m_ack || timeout) begin
          done = 1'b1;
          if (pend_d) begin
            grant = GNT_D;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    case (grant)
      GNT_D:   state_nxt = BUSY_D;
      GNT_I:   state_nxt = BUSY_I;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      m_req    <= 1'b0;
      m_we     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      m_wstrb  <= '0;
      if_rdata <= '0;
      if_valid <= 1'b0;
      d_rdata  <= '0;
      d_valid  <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      if_valid <= 1'b0;
      d_valid  <= 1'b0;

      // Completion of the access in flight.
      if (done) begin
        m_req <= 1'b0;
        if (state == BUSY_D) begin
          d_valid <= 1'b1;
          if (timeout) begin
            d_rdata <= '0;
          end else if (!m_we) begin
            d_rdata <= m_rdata;
          end
        end else begin
          if_valid <= 1'b1;
          if_rdata <= timeout ? '0 : m_rdata;
        end
        if (timeout) begin
          err <= 1'b1;
        end
      end

      // Grant: capture the winner's fields; they stay put until completion.
      case (grant)
        GNT_D: begin
          m_req   <= 1'b1;
          m_we    <= d_we;
          m_addr  <= d_addr;
          m_wdata <= d_wdata;
          m_wstrb <= d_we ? d_wstrb : '0;
        end
        GNT_I: begin
          m_req   <= 1'b1;
          m_we    <= 1'b0;
          m_addr  <= if_addr;
          m_wdata <= '0;
          m_wstrb <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int STRB_W   = DATA_W / 8;
  localparam int MAX_WAIT = 15;

  logic              clk;
  logic              reset;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;
  logic              if_stall;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [STRB_W-1:0] d_wstrb;
  logic [DATA_W-1:0] d_rdata;
  logic              d_valid;
  logic              d_stall;
  logic              m_req;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [STRB_W-1:0] m_wstrb;
  logic              m_ack;
  logic [DATA_W-1:0] m_rdata;
  logic              err;

  mem_port_arbiter #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_valid (if_valid),
    .if_stall (if_stall),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_wstrb  (d_wstrb),
    .d_rdata  (d_rdata),
    .d_valid  (d_valid),
    .d_stall  (d_stall),
    .m_req    (m_req),
    .m_we     (m_we),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_wstrb  (m_wstrb),
    .m_ack    (m_ack),
    .m_rdata  (m_rdata),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: who owns the bus, what each requester should see.
  typedef enum int {O_NONE, O_D, O_I} own_t;

  logic [31:0] mem [logic [31:0]];

  own_t        own = O_NONE;
  int          wcnt = 0;
  int          cur_delay = 0;
  int          delay_cfg = -1;
  bit          force_ack = 0;
  int          n_tx = 0;
  logic [ADDR_W-1:0] e_addr = '0;
  logic              e_we = 1'b0;
  logic [DATA_W-1:0] e_wdata = '0;
  logic [STRB_W-1:0] e_wstrb = '0;
  logic              e_ifv = 1'b0;
  logic              e_dv = 1'b0;
  logic [DATA_W-1:0] e_ifr = '0;
  logic [DATA_W-1:0] e_dr = '0;
  logic              e_err = 1'b0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h5A5A_0F0F;
  endfunction

  function automatic int pick_delay();
    int r;
    if (delay_cfg >= 0) return delay_cfg;
    r = int'($urandom % 16);
    return (r == 0) ? 99 : (r % 4);
  endfunction

  // Memory stub: answers the access the model believes is outstanding.
  task automatic respond();
    if (force_ack) begin
      m_ack   = 1'b1;
      m_rdata = $urandom;
    end else if (own != O_NONE) begin
      m_ack   = (wcnt == cur_delay);
      m_rdata = m_ack ? mem_rd(e_addr) : $urandom;
    end else begin
      m_ack   = ($urandom % 4 == 0);
      m_rdata = $urandom;
    end
  endtask

  // Advance the model by one clock using the inputs presented this cycle.
  task automatic predict();
    logic n_ifv, n_dv, n_err, done, to, pend_d, pend_i;
    logic [DATA_W-1:0] n_ifr, n_dr, v;
    own_t n_own;
    if (reset) begin
      own = O_NONE; wcnt = 0;
      e_addr = '0; e_we = 0; e_wdata = '0; e_wstrb = '0;
      e_ifv = 0; e_dv = 0; e_ifr = '0; e_dr = '0; e_err = 0;
      return;
    end
    n_ifv = 0; n_dv = 0; n_ifr = e_ifr; n_dr = e_dr; n_err = e_err;
    done = 0; to = 0; n_own = own;
    if (own != O_NONE) begin
      if (m_ack) begin
        done = 1;
      end else if (wcnt == MAX_WAIT - 1) begin
        done = 1; to = 1; n_err = 1;
      end else begin
        wcnt++;
      end
      if (done && own == O_D) begin
        n_dv = 1;
        if (to) n_dr = '0;
        else if (!e_we) n_dr = m_rdata;
        else begin
          v = mem_rd(e_addr);
          for (int b = 0; b < STRB_W; b++)
            if (e_wstrb[b]) v[8*b +: 8] = e_wdata[8*b +: 8];
          mem[e_addr] = v;
        end
      end else if (done) begin
        n_ifv = 1;
        n_ifr = to ? '0 : m_rdata;
      end
    end
    pend_d = d_req && !e_dv;
    pend_i = if_req && !e_ifv;
    if (own == O_NONE)  n_own = pend_d ? O_D : (pend_i ? O_I : O_NONE);
    else if (done)      n_own = (own == O_D) ? (pend_i ? O_I : O_NONE) : (pend_d ? O_D : O_NONE);
    if ((own == O_NONE || done) && n_own != O_NONE) begin
      n_tx++;
      wcnt = 0;
      cur_delay = pick_delay();
      if (n_own == O_D) begin
        e_addr = d_addr; e_we = d_we; e_wdata = d_wdata; e_wstrb = d_we ? d_wstrb : '0;
      end else begin
        e_addr = if_addr; e_we = 0; e_wstrb = '0;
      end
    end else if (n_own == O_NONE) begin
      wcnt = 0;
    end
    own = n_own;
    e_ifv = n_ifv; e_dv = n_dv; e_ifr = n_ifr; e_dr = n_dr; e_err = n_err;
  endtask

  task automatic check_outputs();
    check("if_valid", if_valid, e_ifv);
    check("d_valid",  d_valid,  e_dv);
    check("if_rdata", if_rdata, e_ifr);
    check("d_rdata",  d_rdata,  e_dr);
    check("err",      err,      e_err);
    check("m_req",    m_req,    own != O_NONE);
    check("if_stall", if_stall, if_req && !e_ifv);
    check("d_stall",  d_stall,  d_req && !e_dv);
    if (own != O_NONE) begin
      check("m_addr",  m_addr,  e_addr);
      check("m_we",    m_we,    e_we);
      check("m_wstrb", m_wstrb, e_wstrb);
      if (own == O_D) check("m_wdata", m_wdata, e_wdata);
    end
  endtask

  task automatic tick();
    predict();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    reset = 1; if_req = 0; d_req = 0; force_ack = 0; m_ack = 0;
    tick();
    tick();
    reset = 0;
  endtask

  task automatic drive_random();
    if (d_req && e_dv) begin
      d_req = ($urandom % 2 == 0);
    end else if (!d_req) begin
      d_req = ($urandom % 3 == 0);
    end
    if (d_req && (e_dv || !d_stall || own == O_NONE) && !(own == O_D)) begin
      d_we    = $urandom % 2;
      d_addr  = 32'h10 + 4 * ($urandom % 8);
      d_wdata = $urandom;
      d_wstrb = STRB_W'($urandom);
    end
    if (if_req && e_ifv) begin
      if_req = ($urandom % 2 == 0);
    end else if (!if_req) begin
      if_req = ($urandom % 3 == 0);
    end
    if (if_req && !(own == O_I)) begin
      if_addr = 32'h100 + 4 * ($urandom % 8);
    end
  endtask

  int cyc, d_cyc, i_cyc, mreq_n, nv, tx0;
  bit got;

  initial begin
    reset = 1; if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0;
    d_wdata = '0; d_wstrb = '0; m_ack = 0; m_rdata = '0;
    mem[32'h100] = 32'h0050_0093;

    // 1: single fetch, ack on second m_req cycle
    do_reset();
    check("t1_reset_mreq", m_req, 0);
    delay_cfg = 1;
    if_req = 1; if_addr = 32'h100;
    got = 0;
    for (int i = 1; i <= 10; i++) begin
      respond();
      tick();
      if (m_req) check("t1_wstrb", m_wstrb, 0);
      if (if_valid) begin got = 1; cyc = i; break; end
    end
    check("t1_done", got, 1);
    check("t1_latency", cyc, 3);
    check("t1_rdata", if_rdata, 32'h0050_0093);
    if_req = 0;
    respond(); tick();
    check("t1_pulse", if_valid, 0);

    // 2: simultaneous requests, data first, fetch back-to-back
    do_reset();
    delay_cfg = 0;
    d_req = 1; d_we = 1; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'hF;
    if_req = 1; if_addr = 32'h104;
    d_cyc = -1; i_cyc = -1;
    for (int i = 1; i <= 12; i++) begin
      respond();
      tick();
      if (i == 1) check("t2_first_d", m_addr, 32'h2000);
      if (d_valid) begin d_cyc = i; d_req = 0; end
      if (if_valid) begin i_cyc = i; if_req = 0; break; end
    end
    check("t2_order", (d_cyc > 0) && (d_cyc < i_cyc), 1);
    check("t2_b2b", i_cyc - d_cyc, 1);
    check("t2_mem", mem_rd(32'h2000), 32'hDEAD_BEEF);

    // 3: fetch timeout
    do_reset();
    delay_cfg = 99;
    if_req = 1; if_addr = 32'h108;
    mreq_n = 0; got = 0;
    for (int i = 1; i <= 40; i++) begin
      respond();
      tick();
      if (m_req) mreq_n++;
      if (if_valid) begin got = 1; break; end
    end
    check("t3_done", got, 1);
    check("t3_wait", mreq_n, MAX_WAIT);
    check("t3_rdata", if_rdata, 0);
    check("t3_err", err, 1);
    if_req = 0;
    for (int i = 0; i < 3; i++) begin respond(); tick(); end
    check("t3_err_sticky", err, 1);

    // 5: ack while idle is ignored
    force_ack = 1;
    for (int i = 0; i < 3; i++) begin
      respond(); tick();
      check("t5_mreq", m_req, 0);
      check("t5_valid", {if_valid, d_valid}, 0);
    end
    force_ack = 0;

    // 4: reset in the middle of a data access
    do_reset();
    check("t4_err_cleared", err, 0);
    delay_cfg = 99;
    d_req = 1; d_we = 0; d_addr = 32'h20;
    respond(); tick();
    respond(); tick();
    check("t4_busy", m_req, 1);
    reset = 1; respond(); tick();
    reset = 0; d_req = 0;
    check("t4_rst_zero", {m_req, m_we, m_addr, m_wdata, m_wstrb}, 0);
    check("t4_rst_data", {if_rdata, d_rdata, if_valid, d_valid, err}, 0);
    force_ack = 1; respond(); tick();
    force_ack = 0;
    check("t4_no_valid", d_valid, 0);
    respond(); tick();
    check("t4_no_valid2", d_valid, 0);
    check("t4_mreq", m_req, 0);

    // 6: d_req held across d_valid for two loads
    do_reset();
    delay_cfg = 0;
    mem[32'h10] = 32'h1111_0010;
    mem[32'h14] = 32'h2222_0014;
    d_req = 1; d_we = 0; d_addr = 32'h10;
    tx0 = n_tx; nv = 0;
    for (int i = 0; i < 20; i++) begin
      respond();
      tick();
      if (d_valid) begin
        nv++;
        if (nv == 1) begin
          check("t6_rd0", d_rdata, 32'h1111_0010);
          d_addr = 32'h14;
        end else begin
          check("t6_rd1", d_rdata, 32'h2222_0014);
          d_req = 0;
          break;
        end
      end
    end
    for (int i = 0; i < 3; i++) begin respond(); tick(); end
    check("t6_pulses", nv, 2);
    check("t6_tx", n_tx - tx0, 2);

    // Random traffic against the model
    do_reset();
    delay_cfg = -1;
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom % 500 == 0);
      drive_random();
      respond();
      tick();
    end
    reset = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
